// File: rtl/ram_burst_bridge.sv
// ram_burst_bridge: turns valid/ready burst requests into per-beat strobes for the 128-bit RAM helper.
// Define RAM_BRIDGE_RANGE_CHECK_EN to suppress beats outside [RAM_BASE, RAM_BASE+RAM_SIZE).
module ram_burst_bridge #(
  parameter int          ADDR_W   = 64,
  parameter int          IDX_W    = 52,
  parameter logic [63:0] RAM_BASE = 64'h8000_0000,
  parameter logic [63:0] RAM_SIZE = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [127:0]      wdata,
  input  logic [15:0]       wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [127:0]      resp_data,
  output logic              resp_last,
  output logic              ram_en,
  output logic [IDX_W-1:0]  ram_ridx,
  input  logic [127:0]      ram_rdata,
  output logic [IDX_W-1:0]  ram_widx,
  output logic [127:0]      ram_wdata,
  output logic [15:0]       ram_wmask,
  output logic              ram_wen
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_WACK  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               wdata_ready_q, wdata_ready_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ridx_q, ridx_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_last_q, resp_last_d;
  logic [127:0]       resp_data_q, resp_data_d;

  logic               req_accept_s;
  logic               rd_issue_s;
  logic               wr_accept_s;
  logic               in_range_s;
  logic               rd_fire_s;
  logic               wr_fire_s;
  logic [IDX_W-1:0]   base_idx_s;

  // The helper works in whole 16-byte words, so the mapped window must be word aligned.
  if ((RAM_BASE[3:0] != 4'd0) || (RAM_SIZE[3:0] != 4'd0)) begin : g_align_check
    $error("ram_burst_bridge: RAM_BASE and RAM_SIZE must be 16-byte aligned");
  end

  assign req_accept_s = (state_q == S_IDLE) && req_valid && req_ready_q;
  // A read beat may only be issued when the response buffer is free or draining this cycle.
  assign rd_issue_s   = (state_q == S_READ) && !done_q && (!resp_valid_q || resp_ready);
  assign wr_accept_s  = (state_q == S_WRITE) && wdata_valid;
  assign base_idx_s   = IDX_W'((req_addr - ADDR_W'(RAM_BASE)) >> 3'd4);

`ifdef RAM_BRIDGE_RANGE_CHECK_EN
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign in_range_s = (addr_q >= ADDR_W'(RAM_BASE)) &&
                      ((addr_q - ADDR_W'(RAM_BASE)) < ADDR_W'(RAM_SIZE));

  // Byte address of the current beat, stepped alongside the helper index.
  always_comb begin
    addr_d = addr_q;
    if (req_accept_s) begin
      addr_d = {req_addr[ADDR_W-1:4], 4'h0};
    end else if (rd_issue_s || wr_accept_s) begin
      addr_d = addr_q + ADDR_W'(5'd16);
    end else begin
      addr_d = addr_q;
    end
  end

  // Beat address register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end
`else
  assign in_range_s = 1'b1;
`endif

  assign rd_fire_s   = rd_issue_s && in_range_s;
  assign wr_fire_s   = wr_accept_s && in_range_s;

  assign req_ready   = req_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_last   = resp_last_q;
  assign ram_en      = rd_fire_s || wr_fire_s;
  assign ram_wen     = wr_fire_s;
  assign ram_ridx    = rd_fire_s ? idx_q : ridx_q;
  assign ram_widx    = wr_fire_s ? idx_q : widx_q;
  assign ram_wdata   = wr_fire_s ? wdata : 128'd0;
  assign ram_wmask   = wr_fire_s ? wmask : 16'd0;

  // Next-state, beat bookkeeping and response buffer update.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    resp_valid_d = resp_valid_q;
    resp_last_d  = resp_last_q;
    resp_data_d  = resp_data_q;
    ridx_d       = ram_ridx;
    widx_d       = ram_widx;

    case (state_q)
      S_IDLE: begin
        if (req_accept_s) begin
          idx_d   = base_idx_s;
          cnt_d   = req_len;
          done_d  = 1'b0;
          state_d = req_write ? S_WRITE : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          resp_last_d  = 1'b0;
          state_d      = done_q ? S_IDLE : S_READ;
        end else begin
          state_d = S_READ;
        end
        // Issuing overrides the drain above, keeping one beat per cycle under full throughput.
        if (rd_issue_s) begin
          resp_valid_d = 1'b1;
          resp_data_d  = in_range_s ? ram_rdata : 128'd0;
          resp_last_d  = (cnt_q == 8'd0);
          if (cnt_q == 8'd0) begin
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
            idx_d = idx_q + IDX_W'(1'b1);
          end
        end else begin
          done_d = done_q;
        end
      end
      S_WRITE: begin
        if (wr_accept_s) begin
          if (cnt_q == 8'd0) begin
            state_d      = S_WACK;
            resp_valid_d = 1'b1;
            resp_last_d  = 1'b1;
            resp_data_d  = 128'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
            idx_d = idx_q + IDX_W'(1'b1);
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WACK: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_last_d  = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_WACK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d   = (state_d == S_IDLE);
    wdata_ready_d = (state_d == S_WRITE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      idx_q         <= '0;
      ridx_q        <= '0;
      widx_q        <= '0;
      cnt_q         <= 8'd0;
      done_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_last_q   <= 1'b0;
      resp_data_q   <= 128'd0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      wdata_ready_q <= wdata_ready_d;
      idx_q         <= idx_d;
      ridx_q        <= ridx_d;
      widx_q        <= widx_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      resp_valid_q  <= resp_valid_d;
      resp_last_q   <= resp_last_d;
      resp_data_q   <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_bridge.sv
// Bench for ram_burst_bridge: emulates the RAM helper, drives directed and random bursts,
// and checks beats against a word-indexed reference memory built from the address rules.
module tb_ram_burst_bridge;
  localparam int          ADDR_W   = 64;
  localparam int          IDX_W    = 52;
  localparam logic [63:0] RAM_BASE = 64'h8000_0000;
  localparam logic [63:0] RAM_SIZE = 64'h8000_0000;
`ifdef RAM_BRIDGE_RANGE_CHECK_EN
  localparam bit RANGE_ON = 1'b1;
`else
  localparam bit RANGE_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [7:0]        req_len = 8'd0;
  logic              wdata_valid = 1'b0;
  logic              wdata_ready;
  logic [127:0]      wdata = '0;
  logic [15:0]       wmask = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [127:0]      resp_data;
  logic              resp_last;
  logic              ram_en;
  logic [IDX_W-1:0]  ram_ridx;
  logic [127:0]      ram_rdata = '0;
  logic [IDX_W-1:0]  ram_widx;
  logic [127:0]      ram_wdata;
  logic [15:0]       ram_wmask;
  logic              ram_wen;

  always #5 clk = ~clk;

  ram_burst_bridge #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .RAM_BASE(RAM_BASE), .RAM_SIZE(RAM_SIZE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wmask(wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_last(resp_last),
    .ram_en(ram_en), .ram_ridx(ram_ridx), .ram_rdata(ram_rdata), .ram_widx(ram_widx),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] init_pat(input logic [IDX_W-1:0] i);
    return {i[31:0] ^ 32'hA5A5_5A5A, ~i[31:0], 12'h3C5, i};
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old_w, input logic [127:0] new_w,
                                         input logic [15:0] m);
    logic [127:0] r;
    r = old_w;
    for (int b = 0; b < 16; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] beat_idx(input logic [63:0] addr, input int k);
    logic [63:0] off;
    off = (addr - RAM_BASE) / 64'd16;
    return off[IDX_W-1:0] + IDX_W'(k);
  endfunction

  function automatic bit beat_live(input logic [63:0] addr, input int k);
    logic [63:0] a;
    a = (addr / 64'd16) * 64'd16 + 64'(k) * 64'd16;
    return !RANGE_ON || ((a >= RAM_BASE) && (a < RAM_BASE + RAM_SIZE));
  endfunction

  // RAM helper emulation: sparse by low index bits, power-up content from init_pat.
  logic [127:0] hmem [0:1023];
  bit           hval [0:1023];
  int           hgen = 0;

  function automatic logic [127:0] hread(input logic [IDX_W-1:0] i);
    return hval[i[9:0]] ? hmem[i[9:0]] : init_pat(i);
  endfunction

  always @(ram_ridx or hgen or clk) ram_rdata = hread(ram_ridx);

  always @(posedge clk) begin
    if (ram_en && ram_wen) begin
      hmem[ram_widx[9:0]] <= merge(hread(ram_widx), ram_wdata, ram_wmask);
      hval[ram_widx[9:0]] <= 1'b1;
      hgen <= hgen + 1;
    end
  end

  // Reference memory updated from the bench's own view of each write.
  logic [127:0] rmem [logic [IDX_W-1:0]];

  function automatic logic [127:0] rread(input logic [IDX_W-1:0] i);
    return rmem.exists(i) ? rmem[i] : init_pat(i);
  endfunction

  logic [127:0] wq_d [$];
  logic [15:0]  wq_m [$];
  logic [127:0] got  [$];
  int           rd_span;

  always @(negedge clk) begin
    if (!reset) check_eq("wen_without_en", 128'(ram_wen & ~ram_en), 128'd0);
  end

  task automatic send_req(input bit wr, input logic [63:0] addr, input logic [7:0] len);
    bit acc;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
    for (int t = 0; t <= 50; t++) begin
      #2;
      acc = req_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (t == 50) check_eq("req_timeout", 128'd0, 128'd1);
    end
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
  endtask

  task automatic do_write(input logic [63:0] addr, input int len);
    int k;
    bit live;
    logic [IDX_W-1:0] ix;
    send_req(1'b1, addr, 8'(len));
    k = 0;
    for (int t = 0; t < 4000 && k <= len; t++) begin
      wdata_valid = ($urandom_range(0, 3) != 0);
      wdata = wq_d[k];
      wmask = wq_m[k];
      #2;
      if (wdata_valid && wdata_ready) begin
        live = beat_live(addr, k);
        ix   = beat_idx(addr, k);
        check_eq("wr_en", 128'(ram_en), 128'(live));
        check_eq("wr_wen", 128'(ram_wen), 128'(live));
        if (live) begin
          check_eq("wr_idx", 128'(ram_widx), 128'(ix));
          check_eq("wr_data", ram_wdata, wq_d[k]);
          check_eq("wr_mask", 128'(ram_wmask), 128'(wq_m[k]));
          rmem[ix] = merge(rread(ix), wq_d[k], wq_m[k]);
        end
        k++;
      end else begin
        check_eq("wr_idle_en", 128'(ram_en), 128'd0);
      end
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    if (k <= len) check_eq("wr_timeout", 128'(k), 128'(len + 1));
    for (int t = 0; t < 200; t++) begin
      resp_ready = ($urandom_range(0, 1) == 1);
      #2;
      if (resp_valid && resp_ready) begin
        check_eq("ack_last", 128'(resp_last), 128'd1);
        check_eq("ack_data", resp_data, 128'd0);
        break;
      end
      if (t == 199) check_eq("ack_timeout", 128'd0, 128'd1);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: hold off for 5 valid cycles first.
  task automatic do_read(input logic [63:0] addr, input int len, input int mode, input int abort_at);
    int k, t0, t1, stall;
    bit held;
    logic [127:0] prev, exp;
    send_req(1'b0, addr, 8'(len));
    got.delete();
    k = 0; t0 = 0; t1 = 0; stall = 0; held = 1'b0; prev = '0;
    for (int t = 0; t < 4000 && k <= len; t++) begin
      case (mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = ($urandom_range(0, 1) == 1);
        default: resp_ready = (stall >= 5);
      endcase
      #2;
      if (resp_valid && !resp_ready) begin
        check_eq("rd_stall_en", 128'(ram_en), 128'd0);
        if (held) check_eq("rd_hold", resp_data, prev);
        held = 1'b1;
        prev = resp_data;
        stall++;
      end else begin
        held = 1'b0;
      end
      if (resp_valid && resp_ready) begin
        exp = beat_live(addr, k) ? rread(beat_idx(addr, k)) : 128'd0;
        check_eq("rd_data", resp_data, exp);
        check_eq("rd_last", 128'(resp_last), 128'(k == len));
        got.push_back(resp_data);
        if (k == 0) t0 = t;
        t1 = t;
        k++;
        if (k == abort_at) break;
      end
      @(posedge clk); #1;
    end
    rd_span = t1 - t0;
    resp_ready = 1'b0;
    if (abort_at < 0 && k <= len) check_eq("rd_timeout", 128'(k), 128'(len + 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, 128'({req_ready, wdata_ready, resp_valid, resp_last, ram_en, ram_wen}), 128'd0);
    check_eq({tag, "_resp_data"}, resp_data, 128'd0);
    check_eq({tag, "_ridx"}, 128'(ram_ridx), 128'd0);
    check_eq({tag, "_widx"}, 128'(ram_widx), 128'd0);
    check_eq({tag, "_wdata"}, ram_wdata, 128'd0);
    check_eq({tag, "_wmask"}, 128'(ram_wmask), 128'd0);
  endtask

  task automatic fill_random(input int len);
    wq_d.delete(); wq_m.delete();
    for (int i = 0; i <= len; i++) begin
      wq_d.push_back({$urandom, $urandom, $urandom, $urandom});
      wq_m.push_back(($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    int len;
    #1 reset = 1'b1;
    #2 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check_eq("por_req_ready", 128'(req_ready), 128'd1);

    wq_d.delete(); wq_m.delete();
    for (int i = 0; i < 4; i++) begin
      wq_d.push_back(128'(i + 1));
      wq_m.push_back(16'hFFFF);
    end
    do_write(64'h8000_0040, 3);
    do_read(64'h8000_0040, 3, 0, -1);
    check_eq("seq_beats", 128'(got.size()), 128'd4);
    for (int i = 0; i < 4; i++) check_eq("seq_data", got[i], 128'(i + 1));
    check_eq("seq_span", 128'(rd_span), 128'd3);

    do_read(64'h8000_0040, 1, 2, -1);
    check_eq("stall_beats", 128'(got.size()), 128'd2);
    check_eq("stall_b0", got[0], 128'd1);
    check_eq("stall_b1", got[1], 128'd2);

    wq_d.delete(); wq_m.delete();
    wq_d.push_back({128{1'b1}}); wq_m.push_back(16'hFFFF);
    do_write(64'h8000_0100, 0);
    wq_d.delete(); wq_m.delete();
    wq_d.push_back(128'd0); wq_m.push_back(16'h000F);
    do_write(64'h8000_0100, 0);
    do_read(64'h8000_0100, 0, 1, -1);
    check_eq("mask_word", got[0], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000);

    fill_random(1);
    do_write(64'h7FFF_FFF0, 1);
    do_read(64'h7FFF_FFF0, 1, 1, -1);

    do_read(RAM_BASE + 64'($urandom_range(0, 63)) * 64'd16, 255, 0, -1);
    check_eq("long_span", 128'(rd_span), 128'd255);

    for (int n = 0; n < 40; n++) begin
      a   = RAM_BASE + 64'($urandom_range(0, 63)) * 64'd16 + 64'($urandom_range(0, 15));
      len = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        fill_random(len);
        do_write(a, len);
      end else begin
        do_read(a, len, 1, -1);
      end
    end

    do_read(64'h8000_0040, 7, 0, 3);
    reset = 1'b1;
    #1 check_reset_outputs("mid");
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_req_ready", 128'(req_ready), 128'd1);
    check_eq("mid_resp_valid", 128'(resp_valid), 128'd0);

    fill_random(2);
    do_write(64'h8000_0200, 2);
    do_read(64'h8000_0200, 2, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
